branch_resolve_unit: RTL and testbench

- Carries each fetch-stage prediction (taken flag, predicted next PC) alongside its instruction through ID to EX.
- At EX, compares the prediction with the actual branch outcome and drives the BHT update interface (EX PC, EX next PC, predicted flag, jump flag).
- On a mispredict, issues a one-cycle fetch redirect and squashes wrong-path slots.
- Sits between the IF-stage predictor lookup, the EX-stage branch unit and the PC mux; keeps saturating branch/mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 156 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - carries IF predictions to EX, resolves them, drives BHT update/redirect and statistics
module branch_resolve_unit #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             if_valid,
    input  logic [PC_W-1:0]  if_pc,
    input  logic             if_pred_taken,
    input  logic [PC_W-1:0]  if_pred_npc,
    input  logic             ex_is_branch,
    input  logic             ex_taken,
    input  logic [PC_W-1:0]  ex_target,
    output logic             bht_upd_valid,
    output logic [PC_W-1:0]  bht_ex_pc,
    output logic [PC_W-1:0]  bht_ex_npc,
    output logic             bht_ex_pred,
    output logic             bht_ex_jmp,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    input  logic             stat_clr,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mis_cnt
);

    typedef enum logic [0:0] {S_IDLE, S_SQUASH} state_t;

    state_t state, state_next;

    logic            id_valid;
    logic [PC_W-1:0] id_pc;
    logic            id_pred_taken;
    logic [PC_W-1:0] id_pred_npc;

    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic            ex_pred_taken;
    logic [PC_W-1:0] ex_pred_npc;
    logic            ex_resolved;

    logic            resolve;
    logic            act_taken;
    logic            tgt_match;
    logic            cls_correct_t;
    logic            cls_correct_nt;
    logic            cls_miss_nt;
    logic            cls_miss_t;
    logic            do_update;
    logic            mispredict;
    logic            squash;
    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] actual_npc;

    // An EX entry resolves once; a non-branch counts as not taken regardless of ex_taken
    assign resolve        = ex_valid & ~ex_resolved;
    assign act_taken      = ex_is_branch & ex_taken;
    assign tgt_match      = (ex_pred_npc == ex_target);
    assign cls_correct_t  = resolve & act_taken & ex_pred_taken & tgt_match;
    assign cls_miss_nt    = resolve & act_taken & (~ex_pred_taken | ~tgt_match);
    assign cls_miss_t     = resolve & ~act_taken & ex_pred_taken;
    assign cls_correct_nt = resolve & ex_is_branch & ~ex_taken & ~ex_pred_taken;
    assign do_update      = cls_correct_t | cls_correct_nt | cls_miss_nt | cls_miss_t;
    assign mispredict     = cls_miss_nt | cls_miss_t;
    assign seq_pc         = ex_pc + PC_W'(4);
    assign actual_npc     = act_taken ? ex_target : seq_pc;

    // Squash FSM state register
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Squash FSM next state: one SQUASH cycle after each mispredict
    always_comb begin
        state_next = S_IDLE;
        case (state)
            S_IDLE:   state_next = mispredict ? S_SQUASH : S_IDLE;
            S_SQUASH: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Squash FSM output: IF capture is blocked in the mispredict cycle and the following one
    always_comb begin
        squash = mispredict;
        if (state == S_SQUASH) squash = 1'b1;
    end

    // ID/EX tracking: advance when not stalled, wrong-path ID killed on mispredict even under stall
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            id_valid      <= 1'b0;
            id_pc         <= '0;
            id_pred_taken <= 1'b0;
            id_pred_npc   <= '0;
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            ex_pred_taken <= 1'b0;
            ex_pred_npc   <= '0;
            ex_resolved   <= 1'b0;
        end else if (!stall) begin
            ex_valid      <= id_valid & ~mispredict;
            ex_pc         <= id_pc;
            ex_pred_taken <= id_pred_taken;
            ex_pred_npc   <= id_pred_npc;
            ex_resolved   <= 1'b0;
            id_valid      <= if_valid & ~squash;
            id_pc         <= if_pc;
            id_pred_taken <= if_pred_taken;
            id_pred_npc   <= if_pred_npc;
        end else begin
            if (resolve)    ex_resolved <= 1'b1;
            if (mispredict) id_valid    <= 1'b0;
        end
    end

    // Registered BHT update and redirect outputs; BHT fields hold between strobes
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            bht_upd_valid  <= 1'b0;
            bht_ex_pc      <= '0;
            bht_ex_npc     <= '0;
            bht_ex_pred    <= 1'b0;
            bht_ex_jmp     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
        end else begin
            bht_upd_valid  <= do_update;
            redirect_valid <= mispredict;
            if (do_update) begin
                bht_ex_pc   <= ex_pc;
                bht_ex_npc  <= actual_npc;
                bht_ex_pred <= cls_correct_t | cls_miss_t;
                bht_ex_jmp  <= act_taken;
            end
            if (mispredict) redirect_pc <= actual_npc;
        end
    end

    // Saturating statistics; clear takes priority over a same-cycle increment
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else if (stat_clr) begin
            br_cnt  <= '0;
            mis_cnt <= '0;
        end else begin
            if (do_update && (br_cnt != '1))   br_cnt  <= br_cnt + CNT_W'(1);
            if (mispredict && (mis_cnt != '1)) mis_cnt <= mis_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb/tb_branch_resolve_unit.sv - randomized and directed check of branch_resolve_unit against a behavioural model
module tb_branch_resolve_unit;

    localparam int PC_W  = 32;
    localparam int CNT_W = 8;

    logic             clk_sys = 1'b0;
    logic             rst_n;
    logic             stall;
    logic             if_valid;
    logic [PC_W-1:0]  if_pc;
    logic             if_pred_taken;
    logic [PC_W-1:0]  if_pred_npc;
    logic             ex_is_branch;
    logic             ex_taken;
    logic [PC_W-1:0]  ex_target;
    logic             bht_upd_valid;
    logic [PC_W-1:0]  bht_ex_pc;
    logic [PC_W-1:0]  bht_ex_npc;
    logic             bht_ex_pred;
    logic             bht_ex_jmp;
    logic             redirect_valid;
    logic [PC_W-1:0]  redirect_pc;
    logic             stat_clr;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] mis_cnt;

    branch_resolve_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk_sys(clk_sys), .rst_n(rst_n), .stall(stall),
        .if_valid(if_valid), .if_pc(if_pc), .if_pred_taken(if_pred_taken), .if_pred_npc(if_pred_npc),
        .ex_is_branch(ex_is_branch), .ex_taken(ex_taken), .ex_target(ex_target),
        .bht_upd_valid(bht_upd_valid), .bht_ex_pc(bht_ex_pc), .bht_ex_npc(bht_ex_npc),
        .bht_ex_pred(bht_ex_pred), .bht_ex_jmp(bht_ex_jmp),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .stat_clr(stat_clr), .br_cnt(br_cnt), .mis_cnt(mis_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    // Model view: the instruction waiting in ID, the one in EX, whether the slot after a
    // mispredict is still being thrown away, and what the registered outputs must show.
    typedef struct packed {
        logic             id_v;
        logic [31:0]      id_pc;
        logic             id_pt;
        logic [31:0]      id_pn;
        logic             ex_v;
        logic [31:0]      ex_pc;
        logic             ex_pt;
        logic [31:0]      ex_pn;
        logic             ex_done;
        logic             drop_next;
        logic             upd;
        logic [31:0]      bpc;
        logic [31:0]      bnpc;
        logic             bpred;
        logic             bjmp;
        logic             rv;
        logic [31:0]      rpc;
        logic [CNT_W-1:0] br;
        logic [CNT_W-1:0] mis;
    } model_t;

    model_t m, nx;
    int tests = 0;
    int fails = 0;
    localparam logic [CNT_W-1:0] CMAX = {CNT_W{1'b1}};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("upd_valid", 64'(bht_upd_valid), 64'(m.upd));
        chk("ex_pc", 64'(bht_ex_pc), 64'(m.bpc));
        chk("ex_npc", 64'(bht_ex_npc), 64'(m.bnpc));
        chk("ex_pred", 64'(bht_ex_pred), 64'(m.bpred));
        chk("ex_jmp", 64'(bht_ex_jmp), 64'(m.bjmp));
        chk("redirect_valid", 64'(redirect_valid), 64'(m.rv));
        chk("redirect_pc", 64'(redirect_pc), 64'(m.rpc));
        chk("br_cnt", 64'(br_cnt), 64'(m.br));
        chk("mis_cnt", 64'(mis_cnt), 64'(m.mis));
    endtask

    // What happens to the instructions at the coming clock edge, from the outcome rules
    task automatic model_step();
        logic        pending, really_taken, miss, report, p, j;
        logic [31:0] fallthru;
        nx = m;
        pending      = m.ex_v && !m.ex_done;
        really_taken = ex_is_branch && ex_taken;
        fallthru     = m.ex_pc + 32'd4;
        report = 1'b0; miss = 1'b0; p = 1'b0; j = 1'b0;
        if (pending) begin
            if (really_taken && m.ex_pt && (m.ex_pn == ex_target)) begin report = 1; p = 1; j = 1; end
            else if (really_taken)                                 begin report = 1; miss = 1; p = 0; j = 1; end
            else if (m.ex_pt)                                      begin report = 1; miss = 1; p = 1; j = 0; end
            else if (ex_is_branch)                                 begin report = 1; p = 0; j = 0; end
        end
        nx.upd = report;
        if (report) begin
            nx.bpc   = m.ex_pc;
            nx.bnpc  = really_taken ? ex_target : fallthru;
            nx.bpred = p;
            nx.bjmp  = j;
        end
        nx.rv = miss;
        if (miss) nx.rpc = really_taken ? ex_target : fallthru;
        if (stat_clr) begin
            nx.br = '0; nx.mis = '0;
        end else begin
            if (report && m.br != CMAX) nx.br = m.br + 1'b1;
            if (miss && m.mis != CMAX)  nx.mis = m.mis + 1'b1;
        end
        if (!stall) begin
            nx.ex_v    = m.id_v && !miss;
            nx.ex_pc   = m.id_pc;
            nx.ex_pt   = m.id_pt;
            nx.ex_pn   = m.id_pn;
            nx.ex_done = 1'b0;
            nx.id_v    = if_valid && !(miss || m.drop_next);
            nx.id_pc   = if_pc;
            nx.id_pt   = if_pred_taken;
            nx.id_pn   = if_pred_npc;
        end else begin
            if (pending) nx.ex_done = 1'b1;
            if (miss)    nx.id_v = 1'b0;
        end
        nx.drop_next = miss;
    endtask

    task automatic tick();
        if (rst_n) model_step();
        @(posedge clk_sys);
        if (rst_n) m = nx;
        else       m = '0;
        @(negedge clk_sys);
        compare_model();
    endtask

    task automatic set_if(input logic v, input logic [31:0] pc, input logic pt, input logic [31:0] pn);
        if_valid = v; if_pc = pc; if_pred_taken = pt; if_pred_npc = pn;
    endtask

    task automatic set_ex(input logic b, input logic t, input logic [31:0] tgt);
        ex_is_branch = b; ex_taken = t; ex_target = tgt;
    endtask

    int upd_seen, rv_seen;

    initial begin
        m = '0;
        rst_n = 1'b0; stall = 1'b0; stat_clr = 1'b0;
        set_if(0, 0, 0, 0); set_ex(0, 0, 0);
        @(negedge clk_sys);
        @(negedge clk_sys);
        compare_model();
        chk("reset_br_cnt", 64'(br_cnt), 64'd0);
        rst_n = 1'b1;

        // Reset while a valid entry sits in EX
        set_if(1, 32'h100, 1, 32'h200); tick();
        set_if(0, 0, 0, 0); tick();
        set_ex(1, 1, 32'h200); rst_n = 1'b0; tick();
        chk("rst_mid_upd", 64'(bht_upd_valid), 64'd0);
        chk("rst_mid_pc", 64'(bht_ex_pc), 64'd0);
        rst_n = 1'b1; set_ex(0, 0, 0); tick();

        // Correct taken
        set_if(1, 32'h100, 1, 32'h200); tick();
        set_if(0, 0, 0, 0); tick();
        set_ex(1, 1, 32'h200); tick();
        chk("ct_upd", 64'(bht_upd_valid), 64'd1);
        chk("ct_pc", 64'(bht_ex_pc), 64'h100);
        chk("ct_npc", 64'(bht_ex_npc), 64'h200);
        chk("ct_pred", 64'(bht_ex_pred), 64'd1);
        chk("ct_jmp", 64'(bht_ex_jmp), 64'd1);
        chk("ct_rv", 64'(redirect_valid), 64'd0);
        chk("ct_br", 64'(br_cnt), 64'd1);
        chk("ct_mis", 64'(mis_cnt), 64'd0);
        set_ex(0, 0, 0); tick();
        chk("ct_strobe_drop", 64'(bht_upd_valid), 64'd0);
        chk("ct_hold_pc", 64'(bht_ex_pc), 64'h100);

        // Missed taken; wrong-path slots must never be reported
        set_if(1, 32'h104, 0, 0); tick();
        set_if(1, 32'h500, 1, 32'h600); tick();
        set_if(1, 32'h504, 0, 0); set_ex(1, 1, 32'h300); tick();
        chk("mt_rv", 64'(redirect_valid), 64'd1);
        chk("mt_rpc", 64'(redirect_pc), 64'h300);
        chk("mt_pred", 64'(bht_ex_pred), 64'd0);
        chk("mt_jmp", 64'(bht_ex_jmp), 64'd1);
        chk("mt_mis", 64'(mis_cnt), 64'd1);
        set_if(1, 32'h508, 0, 0); tick();
        chk("mt_rv_pulse", 64'(redirect_valid), 64'd0);
        set_if(0, 0, 0, 0); set_ex(1, 1, 32'h999);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mt_no_wrong_path", 64'(bht_upd_valid), 64'd0);
        end
        set_ex(0, 0, 0);

        // Predicted taken, actually not taken
        set_if(1, 32'h108, 1, 32'h200); tick();
        set_if(0, 0, 0, 0); tick();
        set_ex(1, 0, 0); tick();
        chk("wt_rv", 64'(redirect_valid), 64'd1);
        chk("wt_rpc", 64'(redirect_pc), 64'h10C);
        chk("wt_npc", 64'(bht_ex_npc), 64'h10C);
        chk("wt_pred", 64'(bht_ex_pred), 64'd1);
        chk("wt_jmp", 64'(bht_ex_jmp), 64'd0);
        set_ex(0, 0, 0); tick(); tick();

        // Taken with wrong target
        set_if(1, 32'h10C, 1, 32'h200); tick();
        set_if(0, 0, 0, 0); tick();
        set_ex(1, 1, 32'h240); tick();
        chk("tm_rv", 64'(redirect_valid), 64'd1);
        chk("tm_rpc", 64'(redirect_pc), 64'h240);
        chk("tm_pred", 64'(bht_ex_pred), 64'd0);
        chk("tm_jmp", 64'(bht_ex_jmp), 64'd1);
        set_ex(0, 0, 0); tick(); tick();

        // Mispredict held in EX by a 3-cycle stall
        set_if(1, 32'h110, 0, 0); tick();
        set_if(0, 0, 0, 0); tick();
        set_ex(1, 1, 32'h400); stall = 1'b1;
        upd_seen = 0; rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) stall = 1'b0;
            tick();
            upd_seen += int'(bht_upd_valid);
            rv_seen  += int'(redirect_valid);
        end
        chk("stall_upd_once", 64'(upd_seen), 64'd1);
        chk("stall_rv_once", 64'(rv_seen), 64'd1);
        chk("stall_mis", 64'(mis_cnt), 64'd4);
        chk("stall_br", 64'(br_cnt), 64'd5);
        set_ex(0, 0, 0);

        // Saturation of both counters
        stat_clr = 1'b1; tick(); stat_clr = 1'b0;
        chk("clr_br", 64'(br_cnt), 64'd0);
        set_ex(1, 1, 32'h800);
        for (int i = 0; i < 1300; i++) begin
            set_if(1, 32'h1000 + 32'(i * 4), 0, 0);
            tick();
        end
        chk("sat_mis", 64'(mis_cnt), 64'(CMAX));
        chk("sat_br", 64'(br_cnt), 64'(CMAX));

        // Clear coinciding with a resolution
        for (int i = 0; i < 8; i++) begin
            if (m.ex_v && !m.ex_done) begin
                stat_clr = 1'b1; tick(); stat_clr = 1'b0;
                chk("clr_win_br", 64'(br_cnt), 64'd0);
                chk("clr_win_mis", 64'(mis_cnt), 64'd0);
                break;
            end
            tick();
            if (i == 7) chk("clr_win_found", 64'd0, 64'd1);
        end

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n    = ($urandom_range(0, 399) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            stat_clr = ($urandom_range(0, 49) == 0);
            set_if($urandom_range(0, 4) != 0, 32'($urandom_range(0, 255)) << 2,
                   1'($urandom_range(0, 1)), 32'($urandom_range(0, 7)) << 4);
            set_ex($urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 1) != 0) ? m.ex_pn : (32'($urandom_range(0, 7)) << 4));
            tick();
        end
        rst_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
